// File: rtl/qif_neuron_array.sv
// Time-multiplexed quadratic integrate-and-fire neuron array: one shared datapath,
// per-neuron membrane/refractory state, valid/ready sample stream in, tagged results out.
module qif_neuron_array #(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 4,
  parameter int SHIFT       = 5,
  parameter int V_PEAK      = 50,
  parameter int V_RESET     = -20,
  parameter int REFRAC      = 2,
  localparam int ID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_W-1:0]         in_id,
  input  logic signed [WIDTH-1:0] I_syn,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_id,
  output logic signed [WIDTH-1:0] V_mem,
  output logic                    spike
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 2;

  localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);
  localparam logic signed [WIDTH-1:0] V_PEAK_W  = WIDTH'(V_PEAK);
  localparam logic signed [SW-1:0]    SAT_MAX   = SW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0]    SAT_MIN   = SW'(-(2 ** (WIDTH - 1)));
  localparam logic signed [SW-1:0]    PEAK_S    = SW'(V_PEAK);
  localparam logic [RW-1:0]           REFRAC_W  = RW'(REFRAC);

  if ((V_RESET >= V_PEAK) || (V_PEAK > (2 ** (WIDTH - 1)) - 1) ||
      (V_RESET < -(2 ** (WIDTH - 1))) || (SHIFT >= 2 * WIDTH)) begin : g_param_err
    $error("qif_neuron_array: illegal parameter combination");
  end

  logic signed [WIDTH-1:0] v_q [NUM_NEURONS];
  logic signed [WIDTH-1:0] v_d [NUM_NEURONS];
  logic [RW-1:0]           r_q [NUM_NEURONS];
  logic [RW-1:0]           r_d [NUM_NEURONS];

  logic                    out_valid_q, out_valid_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic signed [WIDTH-1:0] v_mem_q, v_mem_d;
  logic                    spike_q, spike_d;

  logic                    id_ok_s;
  logic                    accept_s;
  logic signed [WIDTH-1:0] v_cur_s;
  logic [RW-1:0]           r_cur_s;
  logic signed [PW-1:0]    v_ext_s;
  logic signed [PW-1:0]    sq_s;
  logic signed [SW-1:0]    sum_s;
  logic signed [SW-1:0]    sat_s;
  logic signed [WIDTH-1:0] res_v_s;
  logic                    res_spike_s;
  logic signed [WIDTH-1:0] next_v_s;
  logic [RW-1:0]           next_r_s;

  // Out-of-range ids are only possible when NUM_NEURONS is not a power of two.
  if ((1 << ID_W) == NUM_NEURONS) begin : g_id_full
    assign id_ok_s = 1'b1;
  end else begin : g_id_part
    assign id_ok_s = (32'(in_id) < 32'(NUM_NEURONS));
  end

  assign in_ready = ~clr & (~out_valid_q | out_ready);
  assign accept_s = in_valid & in_ready;

  // Select the addressed neuron's stored membrane and refractory state.
  always_comb begin
    v_cur_s = V_RESET_W;
    r_cur_s = {RW{1'b0}};
    for (int i = 0; i < NUM_NEURONS; i++) begin
      v_cur_s = (32'(in_id) == i) ? v_q[i] : v_cur_s;
      r_cur_s = (32'(in_id) == i) ? r_q[i] : r_cur_s;
    end
  end

  // Shared QIF update: V + V^2/2^SHIFT + I, widened so the sum never wraps, then clamped.
  always_comb begin
    v_ext_s = PW'(v_cur_s);
    sq_s    = (v_ext_s * v_ext_s) >>> SHIFT;
    sum_s   = SW'(v_cur_s) + SW'(sq_s) + SW'(I_syn);
    if (sum_s > SAT_MAX) begin
      sat_s = SAT_MAX;
    end else if (sum_s < SAT_MIN) begin
      sat_s = SAT_MIN;
    end else begin
      sat_s = sum_s;
    end

    if (r_cur_s != {RW{1'b0}}) begin
      res_v_s     = v_cur_s;
      res_spike_s = 1'b0;
      next_v_s    = v_cur_s;
      next_r_s    = r_cur_s - RW'(1);
    end else if (sat_s >= PEAK_S) begin
      res_v_s     = V_PEAK_W;
      res_spike_s = 1'b1;
      next_v_s    = V_RESET_W;
      next_r_s    = REFRAC_W;
    end else begin
      res_v_s     = sat_s[WIDTH-1:0];
      res_spike_s = 1'b0;
      next_v_s    = sat_s[WIDTH-1:0];
      next_r_s    = {RW{1'b0}};
    end
  end

  // Next state: clr wipes the array but leaves a pending result to drain.
  always_comb begin
    v_d         = v_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    v_mem_d     = v_mem_q;
    spike_d     = spike_q;

    if (clr) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_d[i] = V_RESET_W;
        r_d[i] = {RW{1'b0}};
      end
    end else if (accept_s && id_ok_s) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_d[i] = (32'(in_id) == i) ? next_v_s : v_q[i];
        r_d[i] = (32'(in_id) == i) ? next_r_s : r_q[i];
      end
    end else begin
      v_d = v_q;
      r_d = r_q;
    end

    if (accept_s && id_ok_s) begin
      out_valid_d = 1'b1;
      out_id_d    = in_id;
      v_mem_d     = res_v_s;
      spike_d     = res_spike_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= V_RESET_W;
        r_q[i] <= {RW{1'b0}};
      end
      out_valid_q <= 1'b0;
      out_id_q    <= {ID_W{1'b0}};
      v_mem_q     <= {WIDTH{1'b0}};
      spike_q     <= 1'b0;
    end else begin
      v_q         <= v_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      v_mem_q     <= v_mem_d;
      spike_q     <= spike_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign V_mem     = v_mem_q;
  assign spike     = spike_q;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed bench for qif_neuron_array: behavioural neuron model feeds a result scoreboard.
module tb_qif_neuron_array;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_id;
  logic signed [7:0] I_syn;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_id;
  logic signed [7:0] V_mem;
  logic              spike;

  typedef struct {
    int id;
    int v;
    int s;
  } res_t;

  res_t sb[$];
  int   v_m[4];
  int   r_m[4];
  bit   exp_ov;
  int   checks;
  int   failures;

  qif_neuron_array #(
    .WIDTH(8), .NUM_NEURONS(4), .SHIFT(5), .V_PEAK(50), .V_RESET(-20), .REFRAC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .I_syn(I_syn),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .V_mem(V_mem), .spike(spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      v_m[i] = -20;
      r_m[i] = 0;
    end
  endtask

  // One clock: check handshake and presented result, update model on accept, advance.
  task automatic tick();
    bit   exp_ready;
    bit   acc;
    int   v;
    int   sum;
    int   sat;
    res_t e;
    #1;
    exp_ready = !clr && (!exp_ov || out_ready);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov && sb.size() > 0) begin
      check("out_id", out_id, sb[0].id);
      check("V_mem", V_mem, sb[0].v);
      check("spike", spike, sb[0].s);
      if (out_ready) void'(sb.pop_front());
    end
    acc = in_valid && exp_ready;
    if (acc) begin
      e.id = in_id;
      v = v_m[in_id];
      if (r_m[in_id] > 0) begin
        r_m[in_id] = r_m[in_id] - 1;
        e.v = v;
        e.s = 0;
      end else begin
        sum = v + (v * v) / 32 + int'(I_syn);
        sat = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
        if (sat >= 50) begin
          e.v = 50;
          e.s = 1;
          v_m[in_id] = -20;
          r_m[in_id] = 2;
        end else begin
          e.v = sat;
          e.s = 0;
          v_m[in_id] = sat;
        end
      end
      sb.push_back(e);
    end
    if (clr) model_reset();
    if (acc) exp_ov = 1'b1;
    else if (out_ready) exp_ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input int isyn);
    in_valid = 1'b1;
    in_id    = 2'(id);
    I_syn    = 8'(isyn);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_ov    = 1'b0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_id     = 2'd0;
    I_syn     = 8'sd0;
    out_ready = 1'b1;
    model_reset();

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_id", out_id, 0);
    check("rst_V_mem", V_mem, 0);
    check("rst_spike", spike, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Leak toward rest from V_RESET
    send(0, 0);
    send(0, 0);
    check("t1_second", V_mem, -6);
    tick();

    // Spike, refractory, re-arm
    send(1, 30);
    send(1, 30);
    check("t2_spike", spike, 1);
    check("t2_peak", V_mem, 50);
    send(1, 30);
    send(1, 30);
    send(1, 30);
    check("t2_rearm", V_mem, 22);

    // Saturation and interleaved independence
    send(2, -128);
    check("t3_sat", V_mem, -128);
    send(0, 10);
    send(3, 5);
    send(0, -3);
    send(3, 60);
    send(3, 0);
    send(0, 0);
    tick();

    // Backpressure hold, then full-throughput release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_id     = 2'd3;
    I_syn     = 8'sd1;
    tick();
    in_id = 2'd0;
    I_syn = 8'sd7;
    repeat (5) tick();
    out_ready = 1'b1;
    tick();
    send(1, 0);
    send(2, 5);
    send(3, -1);
    tick();

    // Synchronous clear blocks accept and wipes state
    clr = 1'b1;
    tick();
    clr = 1'b0;
    send(1, 30);
    check("t5_pre", V_mem, 22);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_id    = 2'd1;
    I_syn    = 8'sd30;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    send(1, 0);
    check("t5_post", V_mem, -8);

    // Async reset mid-stream with id1 refractory
    send(1, 30);
    send(1, 30);
    check("t6_spike", spike, 1);
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_id", out_id, 0);
    check("t6_V_mem", V_mem, 0);
    check("t6_spike0", spike, 0);
    model_reset();
    sb.delete();
    exp_ov = 1'b0;
    rst_n  = 1'b1;
    send(1, 30);
    check("t6_after", V_mem, 22);
    tick();
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
